// File: rtl/sd_word_decimator_pkg.sv
// Shared sigma-delta helpers: datapath width functions and the
// popcount-to-signed-density conversion used by the word decimator.
package sd_word_decimator_pkg;

   // Priming captures swallowed before the comb output is trustworthy.
   localparam int PRIME_CAPTURES = 2;

   // Width of the signed per-word density value (-OUTLEN..+OUTLEN).
   function automatic int f_pw(input int outlen);
      return $clog2(outlen) + 2;
   endfunction

   // Integrator / comb width: density width plus CIC2 growth over DEC words.
   function automatic int f_ow(input int outlen, input int dec);
      return f_pw(outlen) + 2 * $clog2(dec);
   endfunction

   // Map a ones-count to a zero-centred density: 2*pop - OUTLEN.
   function automatic int f_pc_signed(input int pop, input int outlen);
      return 2 * pop - outlen;
   endfunction

endpackage

// File: rtl/sd_word_decimator_if.sv
// Word-stream interface of the decimator: word strobe, phase realign,
// and the filtered sample with its valid pulse.
interface sd_word_decimator_if #(
   parameter int OUTLEN = 16,
   parameter int OW     = 12
);
   logic              en;
   logic [OUTLEN-1:0] sdIn;
   logic              sync;
   logic [OW-1:0]     out;
   logic              outValid;

   modport master (
      output en,
      output sdIn,
      output sync,
      input  out,
      input  outValid
   );

   modport slave (
      input  en,
      input  sdIn,
      input  sync,
      output out,
      output outValid
   );
endinterface

// File: rtl/sd_word_decimator_popcount.sv
// Combinational ones-count of one sigma-delta word.
module sd_popcount #(
   parameter int OUTLEN = 16
) (
   input  logic [OUTLEN-1:0]         i_word,
   output logic [$clog2(OUTLEN):0]   o_count
);
   localparam int CW = $clog2(OUTLEN) + 1;

   // Sum every bit of the word; order of samples is irrelevant to density.
   always_comb begin
      o_count = '0;
      for (int i = 0; i < OUTLEN; i++) begin
         o_count = o_count + CW'(i_word[i]);
      end
   end
endmodule

// File: rtl/sd_word_decimator.sv
// Second-stage sigma-delta decimator: per-word density, two integrators,
// DEC:1 down-sampling, two-tap differentiator comb, priming suppression.
module sd_word_decimator
   import sd_word_decimator_pkg::*;
#(
   parameter int OUTLEN = 16,
   parameter int DEC    = 8
) (
   input  logic                 clk,
   input  logic                 rstN,
   sd_word_decimator_if.slave   bus
);
   localparam int PW = f_pw(OUTLEN);
   localparam int OW = f_ow(OUTLEN, DEC);
   localparam int CW = $clog2(OUTLEN) + 1;
   localparam int NW = $clog2(DEC);
   localparam logic [NW-1:0] CNT_LAST  = NW'(DEC - 1);
   localparam logic [1:0]    PRIME_MAX = 2'(PRIME_CAPTURES);

   logic [CW-1:0] w_pop;
   logic [PW-1:0] w_pc;
   logic [OW-1:0] w_pc_ext;
   logic [OW-1:0] w_comb;

   logic [PW-1:0] r_pc;
   logic          r_pc_valid;
   logic [OW-1:0] r_int1;
   logic [OW-1:0] r_int2;
   logic [NW-1:0] r_cnt;
   logic          r_cap_pend;
   logic [OW-1:0] r_s;
   logic          r_cap_valid;
   logic [OW-1:0] r_s1;
   logic [OW-1:0] r_s2;
   logic [1:0]    r_prime;
   logic [OW-1:0] r_out;
   logic          r_out_valid;

   sd_popcount #(.OUTLEN(OUTLEN)) u_popcount (
      .i_word  (bus.sdIn),
      .o_count (w_pop)
   );

   assign w_pc     = PW'(f_pc_signed(int'(w_pop), OUTLEN));
   assign w_pc_ext = {{(OW-PW){r_pc[PW-1]}}, r_pc};
   // Second difference of the captured integrator samples; wrap is intended.
   assign w_comb   = r_s - {r_s1[OW-2:0], 1'b0} + r_s2;

   // Stage 0: register the signed density of each strobed word.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_pc       <= '0;
         r_pc_valid <= 1'b0;
      end else begin
         r_pc_valid <= bus.en;
         if (bus.en) begin
            r_pc <= w_pc;
         end
      end
   end

   // Stage 1: cascaded integrators and the frame counter; sync restarts the
   // frame so a word strobed on the sync edge becomes index 0.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_int1     <= '0;
         r_int2     <= '0;
         r_cnt      <= '0;
         r_cap_pend <= 1'b0;
      end else begin
         r_cap_pend <= 1'b0;
         if (r_pc_valid) begin
            r_int1 <= r_int1 + w_pc_ext;
            r_int2 <= r_int2 + r_int1;
         end
         if (bus.sync) begin
            r_cnt <= '0;
         end else if (r_pc_valid) begin
            if (r_cnt == CNT_LAST) begin
               r_cnt      <= '0;
               r_cap_pend <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   // Capture the updated second integrator once per frame.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_s         <= '0;
         r_cap_valid <= 1'b0;
      end else begin
         r_cap_valid <= r_cap_pend;
         if (r_cap_pend) begin
            r_s <= r_int2;
         end
      end
   end

   // Stage 2: comb, history shift, and valid pulse once priming is complete.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_s1        <= '0;
         r_s2        <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_prime     <= '0;
      end else begin
         r_out_valid <= 1'b0;
         if (r_cap_valid) begin
            r_out <= w_comb;
            r_s1  <= r_s;
            r_s2  <= r_s1;
         end
         if (bus.sync) begin
            r_prime <= '0;
         end else if (r_cap_valid) begin
            if (r_prime == PRIME_MAX) begin
               r_out_valid <= 1'b1;
            end else begin
               r_prime <= r_prime + 2'd1;
            end
         end
      end
   end

   assign bus.out      = r_out;
   assign bus.outValid = r_out_valid;

endmodule
